tick_gen: RTL and testbench
===========================

TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the width of the divide-value path (ratio range 1..2^WIDTH).
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port enable  input  1  run request; 1 = generate ticks, 0 = halt.
REQ-005 SHALL have port div  input  WIDTH  divide value D; tick ratio R = D+1.
REQ-006 SHALL have port load  input  1  single-cycle strobe capturing div.
REQ-007 SHALL have port tick  output  1  registered one-cycle pulse every R run cycles; drives count input of the downstream 3-bit counter.
REQ-008 SHALL have port clk_out  output  1  registered square wave toggling on each tick (ratio 2R, 50% duty).
REQ-009 SHALL have port running  output  1  1 while in RUN state.
REQ-010 SHALL have port pending  output  1  1 while a loaded div awaits application.

Function
REQ-011 SHALL hold registers: state {IDLE, RUN}, cnt[WIDTH-1:0], div_act[WIDTH-1:0], shadow[WIDTH-1:0], pending, tick, clk_out.
REQ-012 IDLE: tick=0; cnt held equal to div_act; clk_out held; IDLE->RUN at the edge enable=1 is sampled, cnt=div_act.
REQ-013 RUN, cnt!=0: cnt <= cnt-1, tick <= 0.
REQ-014 RUN, cnt==0 (terminal edge): tick <= 1, clk_out <= ~clk_out, cnt <= reload value (REQ-017).
REQ-015 Timing: enable sampled at edge k with div_act=D -> first tick high after edge k+D+1, then once every D+1 cycles; D=0 -> tick continuously high from edge k+1, clk_out toggling every cycle.
REQ-016 load=1 at an edge: shadow <= div, pending <= 1; a later load before application overwrites shadow (last load wins).
REQ-017 Reload at terminal edge: if load=1 same edge, div_act and cnt <= div (input used directly), pending <= 0; else if pending, div_act and cnt <= shadow, pending <= 0; else cnt <= div_act.
REQ-018 IDLE application: load=1 or pending=1 in IDLE -> div_act and cnt <= (load ? div : shadow) at that edge, pending <= 0; never waits for a terminal count.
REQ-019 Ratio changes SHALL never shorten or lengthen the period in progress; new ratio takes effect starting with the period after the terminal edge.
REQ-020 RUN with enable=0 sampled: -> IDLE, tick <= 0, cnt <= div_act (or applied new value per REQ-018), clk_out holds level; re-enable restarts a full period (no residual count).
REQ-021 enable=0 on a terminal edge: IDLE wins; no tick, no clk_out toggle.
REQ-022 cnt arithmetic SHALL be unsigned WIDTH bits; cnt never decrements below 0 (no wrap); D=2^WIDTH-1 gives ratio 2^WIDTH.
REQ-023 running SHALL equal (state==RUN); pending SHALL be the pending register directly.

Reset
REQ-024 reset=0 SHALL immediately, independent of clk, force state=IDLE, cnt=0, div_act=0, shadow=0, pending=0, tick=0, clk_out=0, running=0.
REQ-025 Reset asserted mid-period SHALL discard the partial count and any pending load; first rising edge with reset=1 evaluates normally.

Verification
REQ-026 Reset, load div=3 in IDLE, enable=1 -> tick high 1 cycle every 4 cycles, first after 4 edges; clk_out period 8 cycles, 50% duty.
REQ-027 div=0 loaded, enable=1 -> tick constant 1 from second edge; clk_out toggles every cycle; downstream 3-bit counter next pulses every 8 cycles.
REQ-028 Running at D=5, load div=1 mid-period -> pending=1, current 6-cycle period completes, then ticks every 2 cycles, pending=0 at terminal edge.
REQ-029 load coincident with terminal edge (D=2 -> div=4) -> pending never asserts, next period 5 cycles.
REQ-030 enable dropped 2 cycles before terminal count, re-raised 3 cycles later -> no tick during gap, clk_out level held, next tick D+1 edges after re-enable.
REQ-031 reset pulsed low between clock edges while running with pending=1 -> all outputs 0 immediately, pending cleared, div_act=0 after release.

Source files
------------

// File: rtl/tick_gen.sv
//------------------------------------------------------------------------------
// Module   : tick_gen
// Purpose  : Programmable tick generator. Emits a one-cycle registered pulse
//            every (div+1) run cycles and a square wave that toggles on every
//            tick. The divide value is double-buffered through a shadow
//            register so ratio changes land only on period boundaries.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tick_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,    // asynchronous, active low
  input  logic             enable,
  input  logic [WIDTH-1:0] div,
  input  logic             load,
  output logic             tick,
  output logic             clk_out,
  output logic             running,
  output logic             pending
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_zero = {WIDTH{1'b0}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_div_act;
  logic [WIDTH-1:0] w_div_act_nxt;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] w_shadow_nxt;
  logic             r_pending;
  logic             w_pending_nxt;
  logic             r_tick;
  logic             w_tick_nxt;
  logic             r_clk_out;
  logic             w_clk_out_nxt;

  // Ratio that would be applied if a boundary occurs this cycle: a
  // coincident load wins over the shadow, which wins over the active value.
  logic [WIDTH-1:0] w_apply_val;
  assign w_apply_val = load      ? div      :
                       r_pending ? r_shadow : r_div_act;

  // State register; reset drops straight to IDLE regardless of the clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath decode; every target gets its hold value first.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_div_act_nxt = r_div_act;
    w_shadow_nxt  = load ? div : r_shadow;
    w_pending_nxt = r_pending;
    w_tick_nxt    = 1'b0;
    w_clk_out_nxt = r_clk_out;

    case (r_state)
      IDLE: begin
        // No period in progress, so any new ratio is applied at once and the
        // counter is preset to a full period for the next start.
        w_div_act_nxt = w_apply_val;
        w_cnt_nxt     = w_apply_val;
        w_pending_nxt = 1'b0;
        if (enable) begin
          w_state_nxt = RUN;
        end
      end

      RUN: begin
        if (!enable) begin
          // Halting beats a terminal count: no tick, clk_out holds level,
          // and the residual count is discarded.
          w_state_nxt   = IDLE;
          w_div_act_nxt = w_apply_val;
          w_cnt_nxt     = w_apply_val;
          w_pending_nxt = 1'b0;
        end else if (r_cnt != c_zero) begin
          // Mid-period: count down; a load is parked until the boundary.
          w_cnt_nxt = r_cnt - c_one;
          if (load) begin
            w_pending_nxt = 1'b1;
          end
        end else begin
          // Terminal edge: pulse, toggle, and start the next period with
          // whichever ratio is newest.
          w_tick_nxt    = 1'b1;
          w_clk_out_nxt = ~r_clk_out;
          w_div_act_nxt = w_apply_val;
          w_cnt_nxt     = w_apply_val;
          w_pending_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath registers; reset clears any partial count and parked load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= c_zero;
      r_div_act <= c_zero;
      r_shadow  <= c_zero;
      r_pending <= 1'b0;
      r_tick    <= 1'b0;
      r_clk_out <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_div_act <= w_div_act_nxt;
      r_shadow  <= w_shadow_nxt;
      r_pending <= w_pending_nxt;
      r_tick    <= w_tick_nxt;
      r_clk_out <= w_clk_out_nxt;
    end
  end

  assign tick    = r_tick;
  assign clk_out = r_clk_out;
  assign running = (r_state == RUN);
  assign pending = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_tick_gen.sv
//------------------------------------------------------------------------------
// Module   : tb_tick_gen
// Purpose  : Directed self-checking bench for tick_gen.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tick_gen;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] div;
  logic             load;
  logic             tick;
  logic             clk_out;
  logic             running;
  logic             pending;

  int n_vec;
  int n_err;

  tick_gen #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .div     (div),
    .load    (load),
    .tick    (tick),
    .clk_out (clk_out),
    .running (running),
    .pending (pending)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int tcount;
    int q3;
    n_vec  = 0;
    n_err  = 0;
    reset  = 1'b0;
    enable = 1'b0;
    div    = '0;
    load   = 1'b0;

    // ---- reset state
    repeat (2) step();
    chk("rst_tick",    tick,    0);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_running", running, 0);
    chk("rst_pending", pending, 0);
    reset = 1'b1;

    // ---- D=3 loaded in IDLE, then run: tick every 4, clk_out period 8
    load = 1'b1; div = 8'd3;
    step();
    chk("d3_idle_pending", pending, 0);
    chk("d3_idle_running", running, 0);
    load = 1'b0; enable = 1'b1;
    step();                                   // edge k
    chk("d3_start_running", running, 1);
    chk("d3_start_tick",    tick,    0);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("d3_tick_%0d", i),    tick,    (i % 4 == 0) ? 1 : 0);
      chk($sformatf("d3_clkout_%0d", i),  clk_out, (i >= 4 && i < 8) ? 1 : 0);
    end

    // ---- halt, load D=5 in IDLE, run, change to D=1 mid-period
    enable = 1'b0;
    step();
    chk("halt_running", running, 0);
    chk("halt_tick",    tick,    0);
    load = 1'b1; div = 8'd5;
    step();
    load = 1'b0; enable = 1'b1;
    step();                                   // edge k, cnt=5
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) begin
        load = 1'b1; div = 8'd1;
      end
      step();
      load = 1'b0;
      chk($sformatf("mid_tick_%0d", i),    tick,    (i == 6 || i == 8 || i == 10) ? 1 : 0);
      chk($sformatf("mid_pending_%0d", i), pending, (i >= 3 && i <= 5) ? 1 : 0);
      chk($sformatf("mid_clkout_%0d", i),  clk_out,
          ((i >= 6 && i < 8) || i >= 10) ? 1 : 0);
    end

    // ---- drop enable together with a load of D=2; then load D=4 on terminal
    enable = 1'b0; load = 1'b1; div = 8'd2;
    step();
    chk("term_idle_running", running, 0);
    chk("term_idle_pending", pending, 0);
    chk("term_idle_clkout",  clk_out, 1);
    load = 1'b0; enable = 1'b1;
    step();                                   // edge k, cnt=2
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin
        load = 1'b1; div = 8'd4;
      end
      step();
      load = 1'b0;
      chk($sformatf("term_tick_%0d", i),    tick,    (i == 3 || i == 8) ? 1 : 0);
      chk($sformatf("term_pending_%0d", i), pending, 0);
      chk($sformatf("term_clkout_%0d", i),  clk_out, (i < 3 || i == 8) ? 1 : 0);
    end

    // ---- enable gap two cycles before terminal count, D=4
    for (int j = 1; j <= 16; j++) begin
      if (j == 3) enable = 1'b0;
      if (j == 6) enable = 1'b1;
      step();
      chk($sformatf("gap_running_%0d", j), running, (j >= 3 && j <= 5) ? 0 : 1);
      chk($sformatf("gap_tick_%0d", j),    tick,    (j == 11 || j == 16) ? 1 : 0);
      chk($sformatf("gap_clkout_%0d", j),  clk_out, (j < 11 || j >= 16) ? 1 : 0);
    end

    // ---- asynchronous reset between edges with a load parked
    load = 1'b1; div = 8'd7;
    step();
    load = 1'b0;
    chk("pre_rst_pending", pending, 1);
    chk("pre_rst_clkout",  clk_out, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_pending", pending, 0);
    chk("arst_clkout",  clk_out, 0);
    chk("arst_running", running, 0);
    chk("arst_tick",    tick,    0);
    #1;
    reset = 1'b1;

    // ---- after reset div_act=0: continuous tick, clk_out toggles each cycle
    enable = 1'b1;
    step();                                   // edge k
    chk("d0_start_tick",    tick,    0);
    chk("d0_start_running", running, 1);
    q3 = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("d0_tick_%0d", i),   tick,    1);
      chk($sformatf("d0_clkout_%0d", i), clk_out, i % 2);
      if (tick === 1'b1) q3 = (q3 + 1) % 8;
    end
    chk("d0_down3_wrap", q3, 0);

    // ---- halt on a terminal edge (every edge is terminal at D=0), load max
    enable = 1'b0; load = 1'b1; div = 8'd255;
    step();
    chk("dmax_halt_tick",   tick,    0);
    chk("dmax_halt_clkout", clk_out, 0);
    load = 1'b0; enable = 1'b1;
    step();                                   // edge k, cnt=255
    tcount = 0;
    for (int i = 1; i <= 255; i++) begin
      step();
      if (tick !== 1'b0) tcount++;
    end
    chk("dmax_no_early_tick", tcount, 0);
    step();
    chk("dmax_tick_256",   tick,    1);
    chk("dmax_clkout_256", clk_out, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
